// File: rtl/board_renderer.sv
// Scans the 16x16 board RAM and paints each cell as a CELL_PX x CELL_PX square on the VGA adapter.
// Optional macro BOARD_GRID_LINES_EN draws the top row and left column of every cell in white.
module board_renderer #(
  parameter int          CELL_PX      = 28,
  parameter int          ORIGIN_X     = 96,
  parameter int          ORIGIN_Y     = 16,
  parameter logic [2:0]  EMPTY_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [8:0]  mem_address,
  output logic        mem_read,
  input  logic [2:0]  mem_q,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  output logic [2:0]  oColour,
  output logic        plot
);

  localparam int PW = $clog2(CELL_PX + 1);
  localparam logic [PW-1:0] LAST = PW'(CELL_PX - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LATCH, PAINT, NEXT, DONE} state_t;

  state_t          state_q;
  logic [3:0]      cx_q, cy_q;
  logic [PW-1:0]   px_q, py_q;
  logic [2:0]      cellColour_q;

  logic [PW-1:0]   px_d, py_d;
  logic [3:0]      cx_d, cy_d;
  logic            lastPixel;
  logic [2:0]      latchColour, firstColour, paintColour;
  logic [9:0]      cellX;
  logic [8:0]      cellY;

  always_comb begin
    lastPixel = (px_q == LAST) && (py_q == LAST);
    if (px_q == LAST) begin
      px_d = '0;
      py_d = py_q + 1'b1;
    end else begin
      px_d = px_q + 1'b1;
      py_d = py_q;
    end
    cx_d = cx_q + 4'd1;
    cy_d = (cx_q == 4'hF) ? cy_q + 4'd1 : cy_q;
    latchColour = (mem_q == 3'b000) ? EMPTY_COLOUR : mem_q;
    cellX = 10'(ORIGIN_X) + 10'(cx_q) * 10'(CELL_PX);
    cellY = 9'(ORIGIN_Y) + 9'(cy_q) * 9'(CELL_PX);
`ifdef BOARD_GRID_LINES_EN
    firstColour = 3'b111;
    paintColour = (px_d == '0 || py_d == '0) ? 3'b111 : cellColour_q;
`else
    firstColour = latchColour;
    paintColour = cellColour_q;
`endif
  end

  // Outputs are loaded on the transition into a state, so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      px_q         <= '0;
      py_q         <= '0;
      cellColour_q <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_read     <= 1'b0;
      mem_address  <= '0;
      plot         <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oColour      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done     <= 1'b0;
          plot     <= 1'b0;
          mem_read <= 1'b0;
          busy     <= 1'b0;
          if (start) begin
            state_q     <= FETCH;
            cx_q        <= '0;
            cy_q        <= '0;
            busy        <= 1'b1;
            mem_read    <= 1'b1;
            mem_address <= '0;
          end
        end
        FETCH: begin
          mem_read <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: state_q <= LATCH;
        LATCH: begin
          cellColour_q <= latchColour;
          px_q         <= '0;
          py_q         <= '0;
          plot         <= 1'b1;
          oX           <= cellX;
          oY           <= cellY;
          oColour      <= firstColour;
          state_q      <= PAINT;
        end
        PAINT: begin
          if (lastPixel) begin
            plot    <= 1'b0;
            state_q <= NEXT;
          end else begin
            px_q    <= px_d;
            py_q    <= py_d;
            oX      <= cellX + 10'(px_d);
            oY      <= cellY + 9'(py_d);
            oColour <= paintColour;
          end
        end
        NEXT: begin
          cx_q <= cx_d;
          cy_q <= cy_d;
          if (cx_q == 4'hF && cy_q == 4'hF) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            state_q     <= FETCH;
            mem_read    <= 1'b1;
            mem_address <= {1'b0, cy_d, cx_d};
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: a board-level model queues expected reads, pixels and done
// timing per render, and a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_board_renderer;

  localparam int         CELL        = 4;
  localparam int         OX          = 96;
  localparam int         OY          = 16;
  localparam logic [2:0] EMPTY       = 3'b010;
  localparam int         CELL_CYCLES = CELL * CELL + 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, mem_read, plot;
  logic [8:0] mem_address;
  logic [2:0] mem_q = 3'b000;
  logic [9:0] oX;
  logic [8:0] oY;
  logic [2:0] oColour;

  board_renderer #(
    .CELL_PX(CELL), .ORIGIN_X(OX), .ORIGIN_Y(OY), .EMPTY_COLOUR(EMPTY)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_q(mem_q),
    .oX(oX), .oY(oY), .oColour(oColour), .plot(plot)
  );

  always #5 clock = ~clock;

  logic [2:0] mem [256];
  logic [2:0] memPipe = 3'b000;
  int         cycle = 0;
  int         checks = 0, errors = 0;
  int         plotCount = 0, readCount = 0, doneCount = 0;
  int         addrQ[$], pixQ[$], doneQ[$];
  bit         expectIdle = 1'b0;
  logic [2:0] palette [4];

  // Board RAM with two cycles of read latency.
  always @(posedge clock) begin
    cycle   <= cycle + 1;
    memPipe <= mem_address[8] ? 3'b000 : mem[mem_address[7:0]];
    mem_q   <= memPipe;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int expectedPixel(input int cx, input int cy, input int px, input int py,
                                       input logic [2:0] v);
    int x, y, c;
    x = OX + cx * CELL + px;
    y = OY + cy * CELL + py;
    c = int'(v);
`ifdef BOARD_GRID_LINES_EN
    if (px == 0 || py == 0) c = 7;
`endif
    return (x << 12) | (y << 3) | c;
  endfunction

  // Loads the expected render of the current board, then pulses start.
  task automatic applyStimulus();
    logic [2:0] v;
    @(posedge clock); #1;
    plotCount = 0;
    readCount = 0;
    for (int n = 0; n < 256; n++) begin
      addrQ.push_back(n);
      v = (mem[n] == 3'b000) ? EMPTY : mem[n];
      for (int py = 0; py < CELL; py++)
        for (int px = 0; px < CELL; px++)
          pixQ.push_back(expectedPixel(n % 16, n / 16, px, py, v));
    end
    doneQ.push_back(cycle + 1 + 256 * CELL_CYCLES);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    int seen, n;
    seen = doneCount;
    n = 0;
    while (doneCount == seen && n < 256 * CELL_CYCLES + 100) begin
      @(negedge clock);
      n++;
    end
    if (doneCount == seen) checkOutput("done timeout", 0, 1);
    @(negedge clock);
    checkOutput("plot count", plotCount, 256 * CELL * CELL);
    checkOutput("read count", readCount, 256);
    checkOutput("pixels pending", pixQ.size(), 0);
    checkOutput("reads pending", addrQ.size(), 0);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 256; i++) mem[i] = palette[$urandom_range(0, 3)];
  endtask

  // Monitor: compares every DUT read, pixel and done pulse against the queued model.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        expectIdle = 1'b0;
      end else begin
        if (expectIdle) begin
          checkOutput("busy after done", int'(busy), 0);
          checkOutput("done width", int'(done), 0);
          expectIdle = 1'b0;
        end
        if (mem_read) begin
          readCount++;
          if (addrQ.size() == 0) checkOutput("spurious mem_read", int'(mem_address), -1);
          else checkOutput("mem_address", int'(mem_address), addrQ.pop_front());
        end
        if (plot) begin
          plotCount++;
          if (pixQ.size() == 0) checkOutput("spurious plot", int'({oX, oY, oColour}), -1);
          else checkOutput("pixel {x,y,colour}", int'({oX, oY, oColour}), pixQ.pop_front());
        end
        if (done) begin
          doneCount++;
          checkOutput("busy in done", int'(busy), 1);
          if (doneQ.size() == 0) checkOutput("spurious done", cycle, -1);
          else checkOutput("done cycle", cycle, doneQ.pop_front());
          expectIdle = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    palette[0] = 3'b000; palette[1] = 3'b100; palette[2] = 3'b001; palette[3] = 3'b110;
    for (int i = 0; i < 256; i++) mem[i] = 3'b000;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset plot", int'(plot), 0);
    checkOutput("reset mem_read", int'(mem_read), 0);
    checkOutput("reset oX", int'(oX), 0);
    checkOutput("reset oY", int'(oY), 0);
    checkOutput("reset oColour", int'(oColour), 0);

    $display("[TB] empty board render");
    applyStimulus();
    waitDone();

    $display("[TB] single red cell at (3,5)");
    mem[83] = 3'b100;
    applyStimulus();
    waitDone();

    $display("[TB] last cell yellow, cell 0 blue, stray start mid-render");
    mem[83] = 3'b000;
    mem[255] = 3'b110;
    mem[0] = 3'b001;
    applyStimulus();
    repeat (1000) @(negedge clock);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    waitDone();

    $display("[TB] random board, reset during cell 10");
    fillRandom();
    applyStimulus();
    n = 0;
    while (readCount < 11 && n < 20 * CELL_CYCLES) begin
      @(negedge clock);
      n++;
    end
    checkOutput("reached cell 10", int'(readCount >= 11), 1);
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    checkOutput("plotting before reset", int'(plot), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("plot after reset", int'(plot), 0);
    checkOutput("busy after reset", int'(busy), 0);
    reset = 1'b0;
    addrQ.delete();
    pixQ.delete();
    doneQ.delete();
    applyStimulus();
    waitDone();

    $display("[TB] second random board");
    fillRandom();
    applyStimulus();
    waitDone();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
